// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between CPU (port 0) and loader (port 1)
// Fixed priority to port 0; a starvation counter forces a port-1 grant after MAX_WAIT port-0 wins.
// Optional feature macro: MEM_ARB_LOCK_EN adds lock1 so port 1 can hold the bus across accesses.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  wr0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  wr1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
`ifdef MEM_ARB_LOCK_EN
    input  logic                  lock1,
`endif
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    state_t          state_q, state_d;
    logic            gnt_q, gnt_d, wr_q, wr_d, pick1, lock_win, in_issue, in_ack, rd_done;
    logic [CW-1:0]   wait_q, wait_d;
    logic [DATA_WIDTH-1:0] hold0, hold1;

`ifdef MEM_ARB_LOCK_EN
    assign lock_win = lock1 & req1;
`else
    assign lock_win = 1'b0;
`endif
    assign pick1 = lock_win | (req1 & (~req0 | (wait_q == CNT_MAX)));

    // sequencing IDLE -> ISSUE -> ACK; grant, direction and starvation count latch on leaving IDLE
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        wait_d  = wait_q;
        if (state_q == IDLE) begin
            if (req0 | req1) begin
                state_d = ISSUE;
                gnt_d   = pick1;
                wr_d    = pick1 ? wr1 : wr0;
                wait_d  = (!pick1 && req1) ? ((wait_q == CNT_MAX) ? CNT_MAX : wait_q + 1'b1) : '0;
            end
        end else begin
            state_d = (state_q == ISSUE) ? ACK : IDLE;
        end
    end

    // FSM and arbitration state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            wr_q    <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            wait_q  <= wait_d;
        end
    end

    assign in_issue = state_q == ISSUE;
    assign in_ack   = state_q == ACK;
    assign rd_done  = in_ack & ~wr_q;
    assign busy     = state_q != IDLE;
    assign mem_en   = in_issue;
    assign mem_wr   = in_issue & wr_q;
    assign mem_addr = in_issue ? (gnt_q ? addr1 : addr0) : '0;
    assign mem_din  = in_issue ? (gnt_q ? wdata1 : wdata0) : '0;
    assign ack0     = in_ack & ~gnt_q;
    assign ack1     = in_ack & gnt_q;
    assign rdata0   = (rd_done & ~gnt_q) ? mem_dout : hold0;
    assign rdata1   = (rd_done & gnt_q) ? mem_dout : hold1;

    // read data hold registers, refreshed only by a completed read of their own port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0 <= '0;
            hold1 <= '0;
        end else if (rd_done) begin
            if (gnt_q) hold1 <= mem_dout;
            else hold0 <= mem_dout;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized bench for mem_port_arbiter against a transaction-level model
// Optional feature macro: MEM_ARB_LOCK_EN enables the lock1 scenario.
module tb_mem_port_arbiter;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, busy, mem_en, mem_wr;
    logic [DW-1:0] rdata0, rdata1, mem_din;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout = '0;
`ifdef MEM_ARB_LOCK_EN
    logic          lock1 = 1'b0;
`endif

    logic          init_mem = 1'b0;
    logic [DW-1:0] mem [256];

    int            n_tests = 0;
    int            n_fail = 0;

    // reference model: a transaction occupies the two cycles after its grant edge
    int            age, waits, m_port;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [DW-1:0] hold [2];
    logic [DW-1:0] mem_ref [256];
    logic [1:0]    ack_d1, ack_d2;
    int            gq[$];
    int            exp4[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
`ifdef MEM_ARB_LOCK_EN
        .lock1(lock1),
`endif
        .busy(busy), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 16) ? 16'hBEEF : (16'(i * 257) ^ 16'h5A3C);
    endfunction

    // synchronous memory with registered read data
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_wr) mem[mem_addr] <= mem_din;
            mem_dout <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic check_outputs();
        check("busy", 32'(busy), 32'(age != 0));
        check("mem_en", 32'(mem_en), 32'(age == 1));
        check("mem_wr", 32'(mem_wr), 32'(age == 1 && m_wr));
        check("mem_addr", 32'(mem_addr), (age == 1) ? 32'(m_addr) : 32'd0);
        check("mem_din", 32'(mem_din), (age == 1) ? 32'(m_wdata) : 32'd0);
        check("ack0", 32'(ack0), 32'(age == 2 && m_port == 0));
        check("ack1", 32'(ack1), 32'(age == 2 && m_port == 1));
        check("rdata0", 32'(rdata0), (age == 2 && m_port == 0 && !m_wr) ? 32'(m_rdata) : 32'(hold[0]));
        check("rdata1", 32'(rdata1), (age == 2 && m_port == 1 && !m_wr) ? 32'(m_rdata) : 32'(hold[1]));
        ack_d2 = ack_d1;
        ack_d1 = {age == 2 && m_port == 1, age == 2 && m_port == 0};
    endtask

    // advance the model across the coming rising edge using the inputs now driven
    task automatic model_sample();
        logic lk, p1;
`ifdef MEM_ARB_LOCK_EN
        lk = lock1;
`else
        lk = 1'b0;
`endif
        if (age == 1) begin
            age = 2;
            if (m_wr) mem_ref[m_addr] = m_wdata;
            else m_rdata = mem_ref[m_addr];
        end else if (age == 2) begin
            age = 0;
            if (!m_wr) hold[m_port] = m_rdata;
        end else if (req0 || req1) begin
            if (lk && req1) p1 = 1'b1;
            else if (req0 && req1) p1 = (waits == MW);
            else p1 = req1;
            waits = (!p1 && req1) ? ((waits < MW) ? waits + 1 : MW) : 0;
            m_port = int'(p1);
            m_wr = p1 ? wr1 : wr0;
            m_addr = p1 ? addr1 : addr0;
            m_wdata = p1 ? wdata1 : wdata0;
            age = 1;
        end
    endtask

    task automatic step();
        model_sample();
        @(negedge clk);
        check_outputs();
        if (ack0) gq.push_back(0);
        if (ack1) gq.push_back(1);
    endtask

    task automatic model_reset();
        age = 0;
        waits = 0;
        hold = '{default: '0};
        m_port = 0;
        m_wr = 1'b0;
        m_addr = '0;
        m_wdata = '0;
        m_rdata = '0;
        ack_d1 = '0;
        ack_d2 = '0;
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        init_mem = 1'b1;
        {req0, wr0, req1, wr1} = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
`ifdef MEM_ARB_LOCK_EN
        lock1 = 1'b0;
`endif
        model_reset();
        for (int i = 0; i < 256; i++) mem_ref[i] = init_val(i);
        @(negedge clk);
        @(negedge clk);
        init_mem = 1'b0;
        check_outputs();
        rst_n = 1'b1;
        gq.delete();
    endtask

    task automatic new_req(input int p);
        if (p == 0) begin
            req0 = 1'b1; wr0 = 1'($urandom_range(1)); addr0 = 8'($urandom_range(15)); wdata0 = 16'($urandom);
        end else begin
            req1 = 1'b1; wr1 = 1'($urandom_range(1)); addr1 = 8'($urandom_range(15)); wdata1 = 16'($urandom);
        end
    endtask

    task automatic drive_rand();
        if (ack_d2[0]) begin
            if ($urandom_range(1) == 1) new_req(0);
            else req0 = 1'b0;
        end else if (!req0 && $urandom_range(3) == 0) new_req(0);
        if (ack_d2[1]) begin
            if ($urandom_range(1) == 1) new_req(1);
            else req1 = 1'b0;
        end else if (!req1 && $urandom_range(3) == 0) new_req(1);
`ifdef MEM_ARB_LOCK_EN
        lock1 = ($urandom_range(5) == 0);
`endif
    endtask

    initial begin
        // reset asserted in the middle of a write issue
        reset_all();
        req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h33; wdata0 = 16'hA5A5;
        step();
        check("t1_issue_wr", 32'(mem_wr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_en", 32'(mem_en), 32'd0);
        check("t1_rst_wr", 32'(mem_wr), 32'd0);
        check("t1_rst_busy", 32'(busy), 32'd0);
        check("t1_rst_addr", 32'(mem_addr), 32'd0);
        check("t1_rst_din", 32'(mem_din), 32'd0);
        check("t1_rst_ack0", 32'(ack0), 32'd0);
        model_reset();
        req0 = 1'b0;
        @(negedge clk);
        check("t1_no_ack", 32'(ack0), 32'd0);
        rst_n = 1'b1;
        req0 = 1'b1; wr0 = 1'b0;
        step();
        step();
        check("t1_unwritten", 32'(rdata0), 32'(init_val(8'h33)));
        step();
        req0 = 1'b0;
        step();

        // port 0 read of a preloaded word
        reset_all();
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h10;
        step();
        check("t2_en", 32'(mem_en), 32'd1);
        step();
        check("t2_ack0", 32'(ack0), 32'd1);
        check("t2_rdata0", 32'(rdata0), 32'hBEEF);
        step();
        check("t2_idle", 32'(busy), 32'd0);
        req0 = 1'b0;
        step();
        check("t2_held", 32'(rdata0), 32'hBEEF);

        // port 1 write then port 0 read-back
        req1 = 1'b1; wr1 = 1'b1; addr1 = 8'h20; wdata1 = 16'h1234;
        step();
        check("t3_wr", 32'(mem_wr), 32'd1);
        step();
        check("t3_ack1", 32'(ack1), 32'd1);
        step();
        req1 = 1'b0;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h20;
        step();
        step();
        check("t3_readback", 32'(rdata0), 32'h1234);
        step();
        req0 = 1'b0;
        step();

        // both requests held: port 0 first, then the starvation pattern
        reset_all();
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h03;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 8'h05; wdata1 = 16'h7777;
        step();
        step();
        check("t5_ack0", 32'(ack0), 32'd1);
        check("t5_ack1", 32'(ack1), 32'd0);
        for (int i = 0; i < 40 && gq.size() < 10; i++) step();
        check("t4_count", 32'(gq.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("t4_grant%0d", i), (i < gq.size()) ? 32'(gq[i]) : 32'd2, 32'(exp4[i]));

`ifdef MEM_ARB_LOCK_EN
        // lock streams port 1 regardless of port 0
        reset_all();
        lock1 = 1'b1;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h01;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h02;
        for (int i = 0; i < 40 && gq.size() < 8; i++) step();
        check("t6_count", 32'(gq.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t6_lock%0d", i), (i < gq.size()) ? 32'(gq[i]) : 32'd2, 32'd1);
        lock1 = 1'b0;
        for (int i = 0; i < 10 && gq.size() < 9; i++) step();
        check("t6_after", (gq.size() > 8) ? 32'(gq[8]) : 32'd2, 32'd0);
`endif

        // randomized traffic
        reset_all();
        for (int i = 0; i < 3000; i++) begin
            drive_rand();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
